// File: rtl/root_5_multi_cycle_pkg.sv
// Shared types for the pow_5 / root_5 family: search FSM states and width helpers.
// Latency: n/a (declarations only). Backpressure: n/a.
// Imported by the root search top and its multiply core.
package root_5_multi_cycle_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Multiplies per candidate: cand^1 is loaded, four more products reach cand^5.
    localparam int MUL_STEPS = 4;

    function automatic int root_width(input int width);
        return (width + 4) / 5;
    endfunction

endpackage

// File: rtl/pow_5_multi_cycle_core.sv
// Raises cand to the fifth power by repeated multiplication through one shared multiplier.
// Latency: start edge loads cand, then 4 enabled edges; done is high during the edge producing cand^5.
// Backpressure: none; clk_en freezes the loop, start restarts it unconditionally.
module pow_5_multi_cycle_core
    import root_5_multi_cycle_pkg::*;
#(
    parameter int RW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            start,
    input  logic [RW-1:0]   cand,
    output logic [5*RW-1:0] prod,
    output logic            done
);

    localparam int PW = 5 * RW;

    logic [1:0] cnt;
    logic       active;

    // prod is 5*RW bits, so cand^5 always fits without truncation.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod   <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (clk_en) begin
            if (start) begin
                prod   <= PW'(cand);
                cnt    <= '0;
                active <= 1'b1;
            end else if (active) begin
                prod <= prod * PW'(cand);
                cnt  <= cnt + 2'd1;
                if (done) begin
                    active <= 1'b0;
                end
            end
        end
    end

    assign done = active && (cnt == 2'(MUL_STEPS - 1));

endmodule

// File: rtl/root_5_multi_cycle.sv
// Integer fifth root res = floor(n^(1/5)) by restoring bit-serial search, MSB first.
// Latency: res_vld in the cycle after enabled edge 6*rw from accept; one request per 6*rw+2 cycles.
// Backpressure: n_vld is ignored while busy (dropped, not queued); clk_en low holds all state.
module root_5_multi_cycle
    import root_5_multi_cycle_pkg::*;
#(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         n_vld,
    input  logic [w-1:0] n,
    output logic         busy,
    output logic         res_vld,
    output logic [w-1:0] res
);

    localparam int RW = root_width(w);
    localparam int PW = 5 * RW;
    localparam int BW = (RW > 1) ? $clog2(RW) : 1;

    state_t         state;
    state_t         state_nxt;
    logic [w-1:0]   n_q;
    logic [RW-1:0]  root;
    logic [RW-1:0]  cand;
    logic [RW-1:0]  root_nxt;
    logic [BW-1:0]  bit_idx;
    logic [PW-1:0]  prod;
    logic           start;
    logic           mul_done;
    logic           fits;

    assign cand     = root | (RW'(1) << bit_idx);
    assign fits     = (prod <= PW'(n_q));
    assign root_nxt = fits ? cand : root;

    pow_5_multi_cycle_core #(
        .RW(RW)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clk_en(clk_en),
        .start (start),
        .cand  (cand),
        .prod  (prod),
        .done  (mul_done)
    );

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = 1'b1;
        res_vld   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (n_vld) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                start     = 1'b1;
                state_nxt = MUL;
            end
            MUL: begin
                if (mul_done) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                state_nxt = (bit_idx == '0) ? DONE : LOAD;
            end
            DONE: begin
                res_vld   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            n_q     <= '0;
            root    <= '0;
            bit_idx <= '0;
            res     <= '0;
        end else if (clk_en) begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (n_vld) begin
                        n_q     <= n;
                        root    <= '0;
                        bit_idx <= BW'(RW - 1);
                    end
                end
                CMP: begin
                    // An exact power (prod == n_q) keeps the bit.
                    root <= root_nxt;
                    if (bit_idx == '0) begin
                        res <= w'(root_nxt);
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
